// File: rtl/reg_dump.sv
// Streams registers 0..REG_NUM-1 of a register file to a UART transmitter,
// one 32-bit word at a time, most significant byte first.
module reg_dump #(
    parameter int REG_NUM = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [4:0]  rd_addr,
    input  logic [31:0] rd_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        FIN   = 2'd3
    } state_t;

    localparam logic [4:0] LAST_ADDR = 5'(REG_NUM - 1);

    state_t      r_state;
    logic [4:0]  r_addr;
    logic [1:0]  r_byte_cnt;
    logic [31:0] r_word;
    logic [7:0]  r_tx_data;
    logic        r_tx_valid;
    logic        r_busy;
    logic        r_done;

    // Byte idx 0 is the most significant byte of the word.
    function automatic logic [7:0] sel_byte(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        b = word[7:0];
        case (idx)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

    // tx_valid/tx_ready: a byte moves only in a cycle where both are high;
    // until then tx_data is held unchanged and tx_valid stays high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_byte_cnt <= '0;
            r_word     <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= FETCH;
                        r_addr  <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                FETCH: begin
                    r_word     <= rd_data;
                    r_byte_cnt <= '0;
                    r_tx_data  <= rd_data[31:24];
                    r_tx_valid <= 1'b1;
                    r_state    <= SEND;
                end
                SEND: begin
                    if (tx_ready) begin
                        if (r_byte_cnt != 2'd3) begin
                            r_byte_cnt <= r_byte_cnt + 2'd1;
                            r_tx_data  <= sel_byte(r_word, r_byte_cnt + 2'd1);
                        end else begin
                            r_tx_valid <= 1'b0;
                            if (r_addr == LAST_ADDR) begin
                                r_state <= FIN;
                                r_done  <= 1'b1;
                            end else begin
                                r_addr  <= r_addr + 5'd1;
                                r_state <= FETCH;
                            end
                        end
                    end
                end
                FIN: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rd_addr     = r_addr;
    assign tx_data     = r_tx_data;
    assign tx_valid    = r_tx_valid;
    assign busy        = r_busy;
    assign done        = r_done;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_reg_dump.sv
// Bench for reg_dump: two instances (2 and 32 registers) checked against a
// byte-stream model built from the register contents.
module tb_reg_dump;

    logic clk;
    logic reset;
    logic [1:0]       start_s;
    logic [1:0]       tx_ready_s;
    logic [1:0][4:0]  rd_addr_s;
    logic [1:0][31:0] rd_data_s;
    logic [1:0][7:0]  tx_data_s;
    logic [1:0]       tx_valid_s;
    logic [1:0]       busy_s;
    logic [1:0]       done_s;
    logic [1:0][1:0]  dbg_state_s;

    logic [31:0] rf [2][32];

    logic [7:0] exp_q[$];
    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int done_cnt [2];
    int done_cyc [2];
    int busy_cnt [2];
    bit hold_pend [2];
    logic [7:0] hold_byte [2];
    int held56 = 0;

    reg_dump #(.REG_NUM(2)) dut_a (
        .clk(clk), .reset(reset), .start(start_s[0]),
        .rd_addr(rd_addr_s[0]), .rd_data(rd_data_s[0]),
        .tx_data(tx_data_s[0]), .tx_valid(tx_valid_s[0]), .tx_ready(tx_ready_s[0]),
        .busy(busy_s[0]), .done(done_s[0]), .o_dbg_state(dbg_state_s[0])
    );

    reg_dump #(.REG_NUM(32)) dut_b (
        .clk(clk), .reset(reset), .start(start_s[1]),
        .rd_addr(rd_addr_s[1]), .rd_data(rd_data_s[1]),
        .tx_data(tx_data_s[1]), .tx_valid(tx_valid_s[1]), .tx_ready(tx_ready_s[1]),
        .busy(busy_s[1]), .done(done_s[1]), .o_dbg_state(dbg_state_s[1])
    );

    assign rd_data_s[0] = rf[0][rd_addr_s[0]];
    assign rd_data_s[1] = rf[1][rd_addr_s[1]];

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // scoreboard: pops the expected byte stream on every handshake
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset) begin
                hold_pend[k] = 1'b0;
            end else begin
                if (hold_pend[k]) begin
                    check("hold_valid", 32'(tx_valid_s[k]), 32'd1);
                    check("hold_data", 32'(tx_data_s[k]), 32'(hold_byte[k]));
                end
                if (tx_valid_s[k] && tx_ready_s[k]) begin
                    if (exp_q.size() == 0)
                        check("stream_extra", 32'(exp_q.size()), 32'd1);
                    else
                        check("stream_byte", 32'(tx_data_s[k]), 32'(exp_q.pop_front()));
                end
                hold_pend[k] = tx_valid_s[k] && !tx_ready_s[k];
                hold_byte[k] = tx_data_s[k];
                if (done_s[k]) begin
                    done_cnt[k]++;
                    done_cyc[k] = cyc;
                end
                if (busy_s[k]) busy_cnt[k]++;
                if (k == 0 && tx_valid_s[0] && tx_data_s[0] == 8'h56) held56++;
            end
        end
    end

    // mode: 0 ready high, 1 ready low 3 cycles on byte 2, 2 start re-pulse,
    //       3 register 0 overwritten during SEND, 4 random ready
    task automatic run_dump(input int k, input int nreg, input int mode);
        int  s0;
        int  d0;
        int  exp_lat;
        bit  seen;
        for (int r = 0; r < nreg; r++)
            for (int b = 3; b >= 0; b--)
                exp_q.push_back(8'(rf[k][r] >> (8 * b)));
        d0 = done_cnt[k];
        busy_cnt[k] = 0;
        held56 = 0;
        tx_ready_s[k] = 1'b1;
        @(negedge clk);
        start_s[k] = 1'b1;
        @(posedge clk);
        #1;
        s0 = cyc;
        start_s[k] = 1'b0;
        seen = 1'b0;
        for (int n = 1; n <= 2000 && !seen; n++) begin
            @(posedge clk);
            #1;
            case (mode)
                1: tx_ready_s[k] = !(n >= 3 && n < 6);
                2: start_s[k] = (n == 2);
                3: if (n == 2) rf[k][0] = 32'hFFFF_FFFF;
                4: tx_ready_s[k] = 1'($urandom_range(0, 1));
                default: tx_ready_s[k] = 1'b1;
            endcase
            seen = done_s[k];
        end
        start_s[k] = 1'b0;
        tx_ready_s[k] = 1'b1;
        if (!seen) check("done_timeout", 32'(seen), 32'd1);
        repeat (12) @(negedge clk);
        check("done_count", 32'(done_cnt[k] - d0), 32'd1);
        check("stream_left", 32'(exp_q.size()), 32'd0);
        if (mode != 4) begin
            exp_lat = 5 * nreg + 1 + ((mode == 1) ? 3 : 0);
            check("done_latency", 32'(done_cyc[k] - s0 + 1), 32'(exp_lat));
            check("busy_cycles", 32'(busy_cnt[k]), 32'(exp_lat));
        end
        if (mode == 1) check("held_56", 32'(held56), 32'd4);
        check("idle_busy", 32'(busy_s[k]), 32'd0);
    endtask

    task automatic reset_mid_dump;
        int d0;
        rf[0][0] = 32'h1234_5678;
        rf[0][1] = 32'hDEAD_BEEF;
        for (int r = 0; r < 2; r++)
            for (int b = 3; b >= 0; b--)
                exp_q.push_back(8'(rf[0][r] >> (8 * b)));
        d0 = done_cnt[0];
        tx_ready_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b1;
        @(posedge clk);
        #1;
        start_s[0] = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        check("pre_rst_data", 32'(tx_data_s[0]), 32'hBE);
        check("pre_rst_addr", 32'(rd_addr_s[0]), 32'd1);
        reset = 1'b0;
        #1;
        check("rst_tx_valid", 32'(tx_valid_s[0]), 32'd0);
        check("rst_busy", 32'(busy_s[0]), 32'd0);
        check("rst_rd_addr", 32'(rd_addr_s[0]), 32'd0);
        check("rst_done", 32'(done_s[0]), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("rel_tx_data", 32'(tx_data_s[0]), 32'd0);
        check("rel_busy", 32'(busy_s[0]), 32'd0);
        repeat (6) @(negedge clk);
        check("rst_no_done", 32'(done_cnt[0] - d0), 32'd0);
        check("rst_waits_idle", 32'(busy_s[0]), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        start_s = '0;
        tx_ready_s = '0;
        for (int k = 0; k < 2; k++) begin
            done_cnt[k] = 0;
            done_cyc[k] = 0;
            busy_cnt[k] = 0;
            hold_pend[k] = 1'b0;
            hold_byte[k] = '0;
            for (int i = 0; i < 32; i++) rf[k][i] = '0;
        end
        #2;
        reset = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check("reset_rd_addr", 32'(rd_addr_s[k]), 32'd0);
            check("reset_tx_data", 32'(tx_data_s[k]), 32'd0);
            check("reset_tx_valid", 32'(tx_valid_s[k]), 32'd0);
            check("reset_busy", 32'(busy_s[k]), 32'd0);
            check("reset_done", 32'(done_s[k]), 32'd0);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        rf[0][0] = 32'h1234_5678;
        rf[0][1] = 32'hDEAD_BEEF;
        run_dump(0, 2, 0);
        run_dump(0, 2, 1);
        run_dump(0, 2, 2);
        rf[0][0] = 32'h0000_0001;
        rf[0][1] = 32'hCAFE_F00D;
        run_dump(0, 2, 3);
        for (int t = 0; t < 3; t++) begin
            rf[0][0] = $urandom;
            rf[0][1] = $urandom;
            run_dump(0, 2, 4);
        end

        for (int i = 0; i < 32; i++) rf[1][i] = 32'(i);
        run_dump(1, 32, 0);
        check("final_rd_addr", 32'(rd_addr_s[1]), 32'd31);
        for (int i = 0; i < 32; i++) rf[1][i] = $urandom;
        run_dump(1, 32, 4);
        check("final_rd_addr_rand", 32'(rd_addr_s[1]), 32'd31);

        reset_mid_dump();
        rf[0][0] = 32'h1234_5678;
        rf[0][1] = 32'hDEAD_BEEF;
        run_dump(0, 2, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/reg_dump.md
REG_DUMP -- requirements
Module: reg_dump

Interface
REQ-001 Parameter REG_NUM SHALL be: default 32, legal 1..32; number of registers dumped, addresses 0..REG_NUM-1.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 start  input  1  SHALL be the dump request, sampled in IDLE only.
REQ-005 rd_addr  output  5  SHALL be the register-file read address, driven to the register file's rs port.
REQ-006 rd_data  input  32  SHALL be the combinational read data for rd_addr (op1_sub of the register file).
REQ-007 tx_data  output  8  SHALL be the byte offered to the UART transmitter.
REQ-008 tx_valid  output  1  SHALL mark tx_data as valid.
REQ-009 tx_ready  input  1  SHALL mark that the UART transmitter accepts tx_data this cycle.
REQ-010 busy  output  1  SHALL be high in every state except IDLE.
REQ-011 done  output  1  SHALL pulse high for exactly one cycle when a dump completes.

Function
REQ-012 FSM states SHALL be IDLE, FETCH, SEND and FIN.
REQ-013 IDLE with start=1 SHALL go to FETCH next cycle with rd_addr=0; start=0 stays in IDLE.
REQ-014 FETCH SHALL latch rd_data into a 32-bit word register, clear the byte counter, and go to SEND next cycle.
REQ-015 SEND SHALL drive tx_valid=1 and tx_data = word[31:24], [23:16], [15:8], [7:0] for byte counter 0..3 (big-endian, MSB first).
REQ-016 tx_data SHALL stay stable and tx_valid SHALL stay high until the cycle where tx_valid and tx_ready are both 1; only that cycle advances the byte counter.
REQ-017 A handshake on byte 3 with rd_addr < REG_NUM-1 SHALL increment rd_addr and go to FETCH.
REQ-018 A handshake on byte 3 with rd_addr = REG_NUM-1 SHALL go to FIN.
REQ-019 rd_addr SHALL never exceed REG_NUM-1 and SHALL NOT wrap.
REQ-020 FIN SHALL assert done=1 for one cycle and return to IDLE next cycle.
REQ-021 tx_valid SHALL be 0 in IDLE, FETCH and FIN.
REQ-022 start asserted while busy=1 SHALL be ignored, with no queuing.
REQ-023 start held high through FIN SHALL begin a new dump on the first cycle back in IDLE.
REQ-024 The word is captured in FETCH; register-file writes during SEND SHALL NOT alter bytes already latched.
REQ-025 With tx_ready tied high, a dump SHALL take 5*REG_NUM cycles from the first FETCH to FIN, and done SHALL assert 5*REG_NUM+1 cycles after the start cycle.
REQ-026 tx_ready low for any number of cycles SHALL stall SEND indefinitely without losing or duplicating bytes.

Reset
REQ-027 reset=0 SHALL immediately and asynchronously force state=IDLE, rd_addr=0, byte counter=0, word=0, tx_data=0, tx_valid=0, busy=0, done=0.
REQ-028 Reset asserted mid-dump SHALL abort the dump with no done pulse; after release, the block SHALL wait in IDLE for a new start.
REQ-029 Outputs SHALL hold their reset values until the first rising clk edge after reset deasserts.

Verification
REQ-030 REG_NUM=2, r0=0x12345678, r1=0xDEADBEEF, tx_ready=1, start pulse -> bytes 12 34 56 78 DE AD BE EF in order, done 11 cycles after start, busy high for 11 cycles.
REQ-031 Same data, tx_ready low for 3 cycles during byte 0x56 -> 0x56 held stable with tx_valid=1 for 4 cycles, stream unchanged, done delayed 3 cycles.
REQ-032 REG_NUM=32, r[i]=i, tx_ready=1 -> 128 bytes 00 00 00 00 ... 00 00 00 1F, rd_addr ends at 31, done once.
REQ-033 start re-pulsed during SEND of register 0 -> ignored, exactly one dump of 8 bytes, one done.
REQ-034 reset driven low between two clk edges while byte 2 of register 1 is offered -> tx_valid, busy and rd_addr go to 0 without a clk edge, no done; a later start restarts from rd_addr=0.
REQ-035 Register 0 written to 0xFFFFFFFF during SEND of original value 0x00000001 -> bytes 00 00 00 01 emitted.
